// File: rtl/bridge_pkg.sv
// Shared types and helpers for the core-to-memory/I/O bridge.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAM_ACC  = 3'd1,
        RAM_WAIT = 3'd2,
        IO_WAIT  = 3'd3,
        DONE     = 3'd4,
        ERR      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_IO   = 2'd1,
        TGT_NONE = 2'd2
    } target_e;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return (res < 1) ? 1 : res;
    endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decoder: RAM vs. I/O channel vs. unmapped,
// plus channel index and register offset inside the channel.
module bridge_addr_decode
    import bridge_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                NUM_IO     = 4,
    parameter logic [ADDR_W-1:0] IO_BASE    = 16'hFF00,
    parameter int                IO_CH_BITS = 4,
    parameter int                CH_W       = 2
)(
    input  logic [ADDR_W-1:0]     adr,
    output target_e               tgt,
    output logic [CH_W-1:0]       ch,
    output logic [IO_CH_BITS-1:0] ofs
);

    logic [ADDR_W-1:0] rel_s;
    logic [ADDR_W-1:0] chan_s;

    // Classify the address and split I/O space into channel and offset
    always_comb begin
        rel_s  = adr - IO_BASE;
        chan_s = rel_s >> IO_CH_BITS;
        ch     = chan_s[CH_W-1:0];
        ofs    = rel_s[IO_CH_BITS-1:0];
        if (adr < IO_BASE) begin
            tgt = TGT_RAM;
        end else if (chan_s < ADDR_W'(NUM_IO)) begin
            tgt = TGT_IO;
        end else begin
            tgt = TGT_NONE;
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Bridge between the core control FSM and unified RAM / NUM_IO I/O channels.
// RAM accesses use a fixed read latency; I/O accesses use req/ack with timeout.
// All outputs are registered and decoded from the state being entered.
module mem_io_bridge
    import bridge_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter int                NUM_IO     = 4,
    parameter logic [ADDR_W-1:0] IO_BASE    = 16'hFF00,
    parameter int                IO_CH_BITS = 4,
    parameter int                RAM_LAT    = 1,
    parameter int                TIMEOUT    = 255
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_adr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_ack,
    output logic                     cpu_err,
    output logic                     busy,
    output logic [ADDR_W-1:0]        ram_adr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     ram_we,
    output logic                     ram_re,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic [NUM_IO-1:0]        io_sel,
    output logic                     io_we,
    output logic [IO_CH_BITS-1:0]    io_adr,
    output logic [DATA_W-1:0]        io_wdata,
    input  logic [NUM_IO*DATA_W-1:0] io_rdata,
    input  logic [NUM_IO-1:0]        io_ack
);

    localparam int CH_W  = clog2(NUM_IO);
    localparam int TO_W  = clog2(TIMEOUT + 1);
    localparam int LAT_W = clog2(RAM_LAT + 1);
    // One counter serves both the RAM latency and the I/O timeout.
    localparam int CNT_W = (TO_W > LAT_W) ? TO_W : LAT_W;
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RAM_LAT - 1);

    state_e                state_r, state_nxt_s;
    target_e               dec_tgt_s, tgt_r, acc_tgt_s;
    logic [CH_W-1:0]       dec_ch_s, ch_r, acc_ch_s;
    logic [IO_CH_BITS-1:0] dec_ofs_s, ofs_r, acc_ofs_s;
    logic                  we_r, acc_we_s;
    logic [ADDR_W-1:0]     adr_r, acc_adr_s;
    logic [DATA_W-1:0]     wdata_r, acc_wdata_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [DATA_W-1:0]     cap_r, cap_nxt_s;
    logic                  sel_ack_s, io_hit_s;
    logic [DATA_W-1:0]     sel_rdata_s;
    logic [NUM_IO-1:0]     sel_oh_s;
    logic                  ram_acc_s, ram_hold_s, io_act_s;

    bridge_addr_decode #(
        .ADDR_W     (ADDR_W),
        .NUM_IO     (NUM_IO),
        .IO_BASE    (IO_BASE),
        .IO_CH_BITS (IO_CH_BITS),
        .CH_W       (CH_W)
    ) u_decode (
        .adr (cpu_adr),
        .tgt (dec_tgt_s),
        .ch  (dec_ch_s),
        .ofs (dec_ofs_s)
    );

    // Access attributes: live request while accepting, latched copy afterwards
    always_comb begin
        if (state_r == IDLE) begin
            acc_tgt_s   = dec_tgt_s;
            acc_ch_s    = dec_ch_s;
            acc_ofs_s   = dec_ofs_s;
            acc_we_s    = cpu_we;
            acc_adr_s   = cpu_adr;
            acc_wdata_s = cpu_wdata;
        end else begin
            acc_tgt_s   = tgt_r;
            acc_ch_s    = ch_r;
            acc_ofs_s   = ofs_r;
            acc_we_s    = we_r;
            acc_adr_s   = adr_r;
            acc_wdata_s = wdata_r;
        end
    end

    // Channel select one-hot plus ack/read-data of the latched channel only
    always_comb begin
        sel_ack_s   = 1'b0;
        sel_rdata_s = '0;
        sel_oh_s    = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            sel_oh_s[k] = (acc_ch_s == CH_W'(k));
            sel_ack_s   = sel_ack_s | (io_ack[k] & (ch_r == CH_W'(k)));
            sel_rdata_s = sel_rdata_s |
                          (io_rdata[k*DATA_W +: DATA_W] & {DATA_W{ch_r == CH_W'(k)}});
        end
        // Truncated channel bits of an unmapped address must never match.
        io_hit_s  = sel_ack_s & (tgt_r == TGT_IO);
        cnt_inc_s = (cnt_r == TO_MAX) ? cnt_r : cnt_r + CNT_W'(1);
    end

    // Next-state, counter and data-capture logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cap_nxt_s   = cap_r;
        case (state_r)
            IDLE: begin
                if (cpu_req) begin
                    cnt_nxt_s = '0;
                    cap_nxt_s = '0;
                    // Unmapped accesses pass one cycle through IO_WAIT with no
                    // channel selected, so their error lands like a RAM write ack.
                    if (dec_tgt_s == TGT_RAM) begin
                        state_nxt_s = RAM_ACC;
                    end else begin
                        state_nxt_s = IO_WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RAM_ACC: begin
                cnt_nxt_s = '0;
                if (we_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                if (cnt_r == LAT_LAST) begin
                    cap_nxt_s   = ram_rdata;
                    state_nxt_s = DONE;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            IO_WAIT: begin
                cnt_nxt_s = cnt_inc_s;
                if (tgt_r != TGT_IO) begin
                    state_nxt_s = ERR;
                end else if (io_hit_s) begin
                    cap_nxt_s   = we_r ? '0 : sel_rdata_s;
                    state_nxt_s = DONE;
                end else if (cnt_inc_s == TO_MAX) begin
                    state_nxt_s = ERR;
                end else begin
                    state_nxt_s = IO_WAIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
        ram_acc_s  = (state_nxt_s == RAM_ACC);
        ram_hold_s = ram_acc_s | (state_nxt_s == RAM_WAIT);
        io_act_s   = (state_nxt_s == IO_WAIT) & (acc_tgt_s == TGT_IO);
    end

    // State, counter and capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            cap_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            cap_r   <= cap_nxt_s;
        end
    end

    // Latch request attributes and decode results on acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_r   <= TGT_RAM;
            ch_r    <= '0;
            ofs_r   <= '0;
            we_r    <= 1'b0;
            adr_r   <= '0;
            wdata_r <= '0;
        end else if ((state_r == IDLE) && cpu_req) begin
            tgt_r   <= dec_tgt_s;
            ch_r    <= dec_ch_s;
            ofs_r   <= dec_ofs_s;
            we_r    <= cpu_we;
            adr_r   <= cpu_adr;
            wdata_r <= cpu_wdata;
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            ram_adr   <= '0;
            ram_wdata <= '0;
            io_sel    <= '0;
            io_we     <= 1'b0;
            io_adr    <= '0;
            io_wdata  <= '0;
        end else begin
            busy    <= (state_nxt_s != IDLE);
            cpu_ack <= (state_nxt_s == DONE);
            cpu_err <= (state_nxt_s == ERR);
            case (state_nxt_s)
                DONE:    cpu_rdata <= cap_nxt_s;
                ERR:     cpu_rdata <= {DATA_W{1'b1}};
                default: cpu_rdata <= '0;
            endcase
            ram_we    <= ram_acc_s & acc_we_s;
            ram_re    <= ram_acc_s & ~acc_we_s;
            ram_adr   <= ram_hold_s ? acc_adr_s : '0;
            ram_wdata <= (ram_acc_s & acc_we_s) ? acc_wdata_s : '0;
            io_sel    <= io_act_s ? sel_oh_s : '0;
            io_we     <= io_act_s & acc_we_s;
            io_adr    <= io_act_s ? acc_ofs_s : '0;
            io_wdata  <= (io_act_s & acc_we_s) ? acc_wdata_s : '0;
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed cases plus randomized
// accesses checked against a transaction-level reference model.
module tb_mem_io_bridge;

    localparam int          DW   = 16;
    localparam int          AW   = 16;
    localparam int          NIO  = 4;
    localparam int          CHB  = 4;
    localparam int          LAT  = 2;
    localparam int          TMO  = 8;
    localparam logic [15:0] BASE = 16'hFF00;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req, cpu_we;
    logic [AW-1:0]     cpu_adr;
    logic [DW-1:0]     cpu_wdata, cpu_rdata;
    logic              cpu_ack, cpu_err, busy;
    logic [AW-1:0]     ram_adr;
    logic [DW-1:0]     ram_wdata, ram_rdata;
    logic              ram_we, ram_re;
    logic [NIO-1:0]    io_sel;
    logic              io_we;
    logic [CHB-1:0]    io_adr;
    logic [DW-1:0]     io_wdata;
    logic [NIO*DW-1:0] io_rdata;
    logic [NIO-1:0]    io_ack;

    int checks   = 0;
    int failures = 0;

    logic [15:0] dev_mem [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic [15:0] rd_pipe [0:LAT-1];

    mem_io_bridge #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_IO(NIO), .IO_BASE(BASE),
        .IO_CH_BITS(CHB), .RAM_LAT(LAT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .busy(busy),
        .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_re(ram_re), .ram_rdata(ram_rdata), .io_sel(io_sel),
        .io_we(io_we), .io_adr(io_adr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    always #5 clk = ~clk;

    // RAM device: write on strobe, read data appears LAT cycles after ram_re
    assign ram_rdata = rd_pipe[LAT-1];
    always @(posedge clk) begin
        if (ram_we) dev_mem[ram_adr[11:0]] <= ram_wdata;
        rd_pipe[0] <= ram_re ? dev_mem[ram_adr[11:0]] : 16'($urandom);
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One complete access; expectations come from the transaction rules only.
    // d = index of the I/O wait cycle in which the device acks (>= TMO: never).
    task automatic run_access(input logic we, input logic [15:0] adr, input logic [15:0] wdata,
                              input int d, input logic [15:0] ioval, input bit junk, input string name);
        int          lat, chn, we_cnt, re_cnt, strobe_n;
        bit          is_ram, is_io, exp_ok, early, busy_low, io_bad;
        logic [15:0] exp_data, rel, strobe_adr, strobe_wd;
        logic [3:0]  exp_sel, ofs;
        we_cnt = 0; re_cnt = 0; strobe_n = 0; strobe_adr = 16'h0; strobe_wd = 16'h0;
        early = 1'b0; busy_low = 1'b0; io_bad = 1'b0;
        rel    = adr - BASE;
        ofs    = rel[3:0];
        is_ram = (adr < BASE);
        chn    = is_ram ? 0 : int'(rel >> CHB);
        is_io  = !is_ram && (chn < NIO);
        if (is_ram) begin
            lat = we ? 2 : LAT + 2; exp_ok = 1'b1;
            exp_data = we ? 16'h0 : ref_mem[adr[11:0]];
        end else if (!is_io) begin
            lat = 2; exp_ok = 1'b0; exp_data = 16'hFFFF;
        end else if (d < TMO) begin
            lat = d + 2; exp_ok = 1'b1; exp_data = we ? 16'h0 : ioval;
        end else begin
            lat = TMO + 1; exp_ok = 1'b0; exp_data = 16'hFFFF;
        end
        exp_sel = is_io ? 4'(1 << chn) : 4'h0;

        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wdata; io_ack = '0;
        @(negedge clk);
        check_val({name, " idle_before"}, {29'h0, busy, cpu_ack, cpu_err}, 32'h0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (n < lat && (cpu_ack || cpu_err)) early = 1'b1;
            if (!busy) busy_low = 1'b1;
            if (ram_we) begin we_cnt++; strobe_n = n; strobe_adr = ram_adr; strobe_wd = ram_wdata; end
            if (ram_re) begin re_cnt++; strobe_n = n; strobe_adr = ram_adr; end
            if (is_io && n < lat) begin
                if (io_sel !== exp_sel || io_adr !== ofs || io_we !== we || (we && io_wdata !== wdata))
                    io_bad = 1'b1;
            end else if (!is_io && io_sel !== 4'h0) begin
                io_bad = 1'b1;
            end
            if (n == lat) begin
                check_val({name, " ack"}, {31'h0, cpu_ack}, {31'h0, exp_ok});
                check_val({name, " err"}, {31'h0, cpu_err}, {31'h0, !exp_ok});
                check_val({name, " rdata"}, {16'h0, cpu_rdata}, {16'h0, exp_data});
            end
            // Device stimulus for the rest of this cycle
            io_ack = '0;
            if (is_io && n == d + 1) io_ack[chn] = 1'b1;
            if (n == 2) io_ack[(chn + 3) % NIO] = 1'b1;
            if (!is_io && !is_ram) io_ack = 4'($urandom);
            for (int k = 0; k < NIO; k++) io_rdata[k*DW +: DW] = 16'($urandom);
            if (is_io) io_rdata[chn*DW +: DW] = ioval;
            if (junk && n < lat) begin
                cpu_req = 1'($urandom); cpu_we = 1'($urandom);
                cpu_adr = 16'($urandom); cpu_wdata = 16'($urandom);
            end else begin
                cpu_req = 1'b0;
            end
        end
        io_ack = '0;
        check_val({name, " no_early_done"}, {31'h0, early}, 32'h0);
        check_val({name, " busy_held"}, {31'h0, busy_low}, 32'h0);
        check_val({name, " io_outputs"}, {31'h0, io_bad}, 32'h0);
        if (is_ram && we) begin
            check_val({name, " ram_strobe"}, {we_cnt[7:0], re_cnt[7:0], strobe_n[7:0], 8'h0}, {8'd1, 8'd0, 8'd1, 8'h0});
            check_val({name, " ram_wr_bus"}, {strobe_adr, strobe_wd}, {adr, wdata});
            ref_mem[adr[11:0]] = wdata;
        end else if (is_ram) begin
            check_val({name, " ram_strobe"}, {we_cnt[7:0], re_cnt[7:0], strobe_n[7:0], 8'h0}, {8'd0, 8'd1, 8'd1, 8'h0});
            check_val({name, " ram_rd_adr"}, {16'h0, strobe_adr}, {16'h0, adr});
        end else begin
            check_val({name, " ram_quiet"}, we_cnt + re_cnt, 32'h0);
        end
    endtask

    initial begin
        bit          bad;
        int          kind, d;
        logic        we;
        logic [15:0] adr;
        for (int i = 0; i < 4096; i++) begin
            dev_mem[i] = 16'(i * 3 + 7);
            ref_mem[i] = 16'(i * 3 + 7);
        end
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        io_ack = '0; io_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", {31'h0, |{cpu_rdata, cpu_ack, cpu_err, busy, ram_adr, ram_wdata,
                  ram_we, ram_re, io_sel, io_we, io_adr, io_wdata}}, 32'h0);
        @(negedge clk) rst = 1'b1;

        run_access(1'b1, 16'h0010, 16'hBEEF, 0, 16'h0, 1'b0, "ram_wr");
        run_access(1'b1, 16'h0020, 16'h1234, 0, 16'h0, 1'b0, "ram_wr2");
        run_access(1'b0, 16'h0020, 16'h0, 0, 16'h0, 1'b0, "ram_rd");
        run_access(1'b0, 16'h0010, 16'h0, 0, 16'h0, 1'b0, "ram_rd2");
        run_access(1'b0, 16'hFF23, 16'h0, 4, 16'hA5A5, 1'b0, "io_rd_ch2");
        run_access(1'b0, 16'hFF31, 16'h0, 100, 16'h5A5A, 1'b0, "io_timeout");
        run_access(1'b1, 16'hFF05, 16'h7777, TMO - 1, 16'h1111, 1'b0, "io_ack_at_limit");
        run_access(1'b0, 16'hFF14, 16'h0, 0, 16'hC3C3, 1'b0, "io_ack_first");
        run_access(1'b0, 16'hFF50, 16'h0, 0, 16'h0, 1'b0, "unmapped");
        run_access(1'b1, 16'hFFFF, 16'h4242, 0, 16'h0, 1'b0, "unmapped_top");

        // Asynchronous reset in the middle of an I/O wait
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'hFF12;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_pre_sel", {28'h0, io_sel}, 32'h2);
        #2 rst = 1'b0;
        #1;
        check_val("rst_mid_outputs", {31'h0, |{cpu_rdata, cpu_ack, cpu_err, busy, ram_adr, ram_wdata,
                  ram_we, ram_re, io_sel, io_we, io_adr, io_wdata}}, 32'h0);
        @(posedge clk); #3 rst = 1'b1;
        bad = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (cpu_ack || cpu_err || busy) bad = 1'b1;
            io_ack = 4'hF;
        end
        io_ack = '0;
        check_val("rst_no_late_done", {31'h0, bad}, 32'h0);
        run_access(1'b0, 16'hFF12, 16'h0, 2, 16'h9C9C, 1'b0, "post_rst_io");

        // Randomized traffic with junk requests while busy
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1:    adr = 16'($urandom_range(0, 4095));
                2:       adr = BASE + 16'($urandom_range(0, NIO * 16 - 1));
                default: adr = BASE + 16'($urandom_range(NIO * 16, 255));
            endcase
            we = 1'($urandom);
            d  = $urandom_range(0, TMO + 2);
            run_access(we, adr, 16'($urandom), d, 16'($urandom), 1'b1, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
